mux_pipe_reg: RTL and testbench

Parametrised, registered successor to the combinational forwarding/select muxes in the datapath. It selects one of `NUM_IN` operand sources and carries the result through `DEPTH` pipeline registers with valid tracking, stall (hold) and flush (bubble insertion). Out-of-range selects are flagged and counted rather than driven as high-impedance. It sits between hazard/forwarding logic and the next pipeline stage.

---
 rtl/mux_pipe_reg.sv | 83 ++++++++
 tb/tb_mux_pipe_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_reg.sv
// Registered N-way operand select followed by a DEPTH-stage valid-tracked pipeline
// with stall, flush, and sticky/saturating out-of-range select reporting.
module mux_pipe_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_count
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    logic [WIDTH-1:0] mux_data;
    logic             sel_in_range;
    logic             cap_valid;
    logic             err_event;

    // Source select; an out-of-range index yields zero data.
    always_comb begin
        mux_data     = '0;
        sel_in_range = (32'(sel) < NUM_IN);
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                mux_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign cap_valid = in_valid && sel_in_range;
    // A flushed input is still checked; a stalled one is not sampled at all.
    assign err_event = in_valid && !sel_in_range && (flush || !stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_data[i] <= '0;
            end
            stage_valid <= '0;
            sel_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            if (err_event) begin
                sel_err <= 1'b1;
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end

            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_data[i] <= '0;
                end
                stage_valid <= '0;
            end else if (!stall) begin
                stage_data[0]  <= mux_data;
                stage_valid[0] <= cap_valid;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_data[i]  <= stage_data[i-1];
                    stage_valid[i] <= stage_valid[i-1];
                end
            end
        end
    end

    assign data_out  = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Scoreboard bench for mux_pipe_reg: one DEPTH=1 and one DEPTH=3 instance share stimulus;
// a timestamped queue model predicts when each accepted operand must emerge.
module tb_mux_pipe_reg;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] data_in;
    logic [SW-1:0] sel;
    logic          in_valid;
    logic          stall;
    logic          flush;

    logic [W-1:0]  dout [2];
    logic          ov   [2];
    logic          se   [2];
    logic [7:0]    ec   [2];

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .data_out(dout[0]), .out_valid(ov[0]),
        .sel_err(se[0]), .err_count(ec[0])
    );

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .data_out(dout[1]), .out_valid(ov[1]),
        .sel_err(se[1]), .err_count(ec[1])
    );

    always #5 clk = ~clk;

    // Inputs as seen by the most recent rising edge.
    logic           started = 1'b0;
    logic           s_rst, s_flush, s_stall, s_valid;
    logic [SW-1:0]  s_sel;
    logic [N*W-1:0] s_data;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_flush <= flush;
        s_stall <= stall;
        s_valid <= in_valid;
        s_sel   <= sel;
        s_data  <= data_in;
        started <= 1'b1;
    end

    typedef struct {
        logic [W-1:0] data;
        int           tag;
    } ent_t;

    ent_t         sbq [2][$];
    int           adv_cnt [2];
    logic         exp_v   [2];
    logic [W-1:0] exp_d   [2];
    logic         d_known [2];
    logic         exp_err;
    int           exp_cnt;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Model update for the edge just taken, then compare against both instances.
    always @(negedge clk) begin
        if (started) begin
            bit bad_sel;
            int depth;
            bad_sel = (int'(s_sel) >= int'(N));

            if (s_rst) begin
                exp_err = 1'b0;
                exp_cnt = 0;
            end else if ((s_flush || !s_stall) && s_valid && bad_sel) begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end

            for (int k = 0; k < 2; k++) begin
                depth = (k == 0) ? 1 : 3;
                if (s_rst || s_flush) begin
                    sbq[k].delete();
                    exp_v[k]   = 1'b0;
                    exp_d[k]   = '0;
                    d_known[k] = 1'b1;
                end else if (!s_stall) begin
                    adv_cnt[k]++;
                    if (s_valid && !bad_sel) begin
                        ent_t e;
                        e.data = s_data[int'(s_sel)*W +: W];
                        e.tag  = adv_cnt[k];
                        sbq[k].push_back(e);
                    end
                    exp_v[k]   = 1'b0;
                    d_known[k] = 1'b0;
                    if (sbq[k].size() > 0 && sbq[k][0].tag + depth - 1 == adv_cnt[k]) begin
                        exp_v[k]   = 1'b1;
                        exp_d[k]   = sbq[k][0].data;
                        d_known[k] = 1'b1;
                        void'(sbq[k].pop_front());
                    end
                end

                check("out_valid", k, W'(ov[k]), W'(exp_v[k]));
                if (d_known[k]) check("data_out", k, dout[k], exp_d[k]);
                check("sel_err", k, W'(se[k]), W'(exp_err));
                check("err_count", k, W'(ec[k]), W'(exp_cnt));
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [SW-1:0] sl, input logic [N*W-1:0] din);
        @(posedge clk);
        #1;
        rst = r; flush = f; stall = s; in_valid = v; sel = sl; data_in = din;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N*W-1:0] one(input logic [W-1:0] val);
        return {$urandom, $urandom, val};
    endfunction

    initial begin
        logic [N*W-1:0] srcs;
        srcs = {32'h12345678, 32'h0000BBBB, 32'hAAAA0000};
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b1; sel = 2'd1; data_in = rnd_data();
        adv_cnt[0] = 0; adv_cnt[1] = 0;
        exp_err = 1'b0; exp_cnt = 0;

        // Two reset cycles with random inputs
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, rnd_data());
        // Source sweep
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, srcs);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, srcs);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, srcs);
        // Out-of-range select, then saturate the counter
        for (int i = 0; i < 301; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());

        // Stall for two cycles after value 2 enters
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd1));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd2));
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, one(32'd3));
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, one(32'd3));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd3));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd4));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());

        // Full pipeline, then flush together with stall
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd5));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd6));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd7));
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, one(32'd8));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());

        // Reset mid-operation with sel_err set and pipeline full
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, rnd_data());
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, rnd_data());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7),
                 SW'($urandom_range(0, 3)), rnd_data());
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rnd_data());

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
